// File: rtl/mem_access_unit.sv
// Bus-side responder for control-unit memory requests. Runs 8- or 16-bit
// accesses as one or two little-endian byte cycles on the 8-bit system bus.
module mem_access_unit #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        mem_ack,
  output logic [15:0] mem_data,
  output logic        mem_err,
  output logic        busy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        wide_q;
  logic        write_q;
  logic [7:0]  lo_q;
  logic [7:0]  cnt_q;
  logic        bus_active;
  logic        timeout_hit;

  // The wait cycle that brings the counter up to TIMEOUT is the one that aborts.
  assign timeout_hit = !bus_ready && (cnt_q == TIMEOUT - 8'd1);

  // Sequencer: request latch, byte cycles, completion pulse and read result.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= StIdle;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      wide_q   <= 1'b0;
      write_q  <= 1'b0;
      lo_q     <= 8'h00;
      cnt_q    <= 8'h00;
      mem_ack  <= 1'b0;
      mem_err  <= 1'b0;
      mem_data <= 16'h0000;
    end else begin
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_read || req_write) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wide_q  <= req_wide;
            write_q <= req_write;
            cnt_q   <= 8'h00;
            state_q <= StLo;
          end
        end
        StLo: begin
          if (bus_ready) begin
            cnt_q <= 8'h00;
            lo_q  <= bus_rdata;
            if (wide_q) begin
              state_q <= StHi;
            end else begin
              state_q <= StDone;
              mem_ack <= 1'b1;
              if (!write_q) mem_data <= {8'h00, bus_rdata};
            end
          end else if (timeout_hit) begin
            cnt_q    <= 8'h00;
            state_q  <= StDone;
            mem_ack  <= 1'b1;
            mem_err  <= 1'b1;
            mem_data <= 16'hFFFF;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StHi: begin
          if (bus_ready) begin
            cnt_q   <= 8'h00;
            state_q <= StDone;
            mem_ack <= 1'b1;
            if (!write_q) mem_data <= {bus_rdata, lo_q};
          end else if (timeout_hit) begin
            // A wide write aborted here keeps its already-written low byte.
            cnt_q    <= 8'h00;
            state_q  <= StDone;
            mem_ack  <= 1'b1;
            mem_err  <= 1'b1;
            mem_data <= 16'hFFFF;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Strobes only in byte-cycle states, so they drop for at least one cycle between accesses.
  always_comb begin
    bus_active = (state_q == StLo) || (state_q == StHi);
    bus_rd     = bus_active && !write_q;
    bus_wr     = bus_active && write_q;
    busy       = (state_q != StIdle);
    // addr+1 wraps naturally at 16 bits.
    bus_addr   = (state_q == StHi) ? addr_q + 16'd1 : addr_q;
    bus_wdata  = (state_q == StHi) ? wdata_q[15:8] : wdata_q[7:0];
  end

endmodule
